// File: rtl/spm_line_responder_if.sv
// SpMV fetch request/response bundle between a requester and a line memory.
// Ports: mem_req_{val,rdy,transid,addr} request; mem_resp_{val,transid,data} response.
interface spm_line_responder_if #(
    parameter int ADDR_W = 40,
    parameter int LINE_W = 512
) ();
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [5:0]        mem_req_transid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_val;
    logic [5:0]        mem_resp_transid;
    logic [LINE_W-1:0] mem_resp_data;

    modport master (
        output mem_req_val, mem_req_transid, mem_req_addr,
        input  mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );

    modport slave (
        input  mem_req_val, mem_req_transid, mem_req_addr,
        output mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );
endinterface

// File: rtl/spm_line_responder.sv
// Fixed-latency, in-order 64-byte line memory endpoint with credit limit.
// Ports: clk, rst_n (sync, active-low); bus (slave req/resp); resp_hold;
//        ld_val/ld_idx/ld_data backdoor line write; addr_err sticky flag.
module spm_line_responder #(
    parameter int ADDR_W      = 40,
    parameter int LINE_W      = 512,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter int QDEPTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    spm_line_responder_if.slave            bus,
    input  logic                           resp_hold,
    input  logic                           ld_val,
    input  logic [$clog2(DEPTH_LINES)-1:0] ld_idx,
    input  logic [LINE_W-1:0]              ld_data,
    output logic                           addr_err
);
    localparam int IW  = $clog2(DEPTH_LINES);
    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;
    // Stage 0 holds the registered array read; push happens from the
    // last stage so the entry is visible at the FIFO head at T+LATENCY.
    localparam int NST = LATENCY - 1;

    logic              w_hsk;
    logic              w_oor;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic [IW-1:0]     w_idx;
    logic              w_unused_lsb;

    logic [CW-1:0]     r_out;
    logic [NST-1:0]    r_v;
    logic [NST-1:0]    r_z;
    logic [5:0]        r_t [NST];
    logic [LINE_W-1:0] r_d [NST];

    logic [LINE_W-1:0] r_mem [DEPTH_LINES];
    logic [5:0]        r_ft  [QDEPTH];
    logic [LINE_W-1:0] r_fd  [QDEPTH];
    logic [PW:0]       r_wp;
    logic [PW:0]       r_rp;

    assign bus.mem_req_rdy = (r_out < CW'(QDEPTH)) && !ld_val;
    assign w_hsk   = bus.mem_req_val && bus.mem_req_rdy;
    assign w_idx   = bus.mem_req_addr[6+IW-1:6];
    assign w_oor   = |(bus.mem_req_addr >> (6 + IW));
    // Byte offset within the line has no effect on the read.
    assign w_unused_lsb = ^bus.mem_req_addr[5:0];

    assign w_empty = (r_wp == r_rp);
    assign w_pop   = !w_empty && !resp_hold;
    assign w_push  = r_v[NST-1];

    assign bus.mem_resp_val     = w_pop;
    assign bus.mem_resp_transid = w_pop ? r_ft[r_rp[PW-1:0]] : '0;
    assign bus.mem_resp_data    = w_pop ? r_fd[r_rp[PW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_v      <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            addr_err <= 1'b0;
        end else begin
            r_v[0] <= w_hsk;
            for (int i = 1; i < NST; i++) begin
                r_v[i] <= r_v[i-1];
            end
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            addr_err <= addr_err | (w_hsk & w_oor);
            case ({w_hsk, w_pop})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end

    // Data path: array, payload pipeline and FIFO storage are not reset;
    // only the valid bits and pointers above decide what is live.
    always_ff @(posedge clk) begin
        if (ld_val) r_mem[ld_idx] <= ld_data;
        r_d[0] <= r_mem[w_idx];
        r_t[0] <= bus.mem_req_transid;
        r_z[0] <= w_oor;
        for (int i = 1; i < NST; i++) begin
            r_d[i] <= r_d[i-1];
            r_t[i] <= r_t[i-1];
            r_z[i] <= r_z[i-1];
        end
        if (w_push) begin
            r_ft[r_wp[PW-1:0]] <= r_t[NST-1];
            r_fd[r_wp[PW-1:0]] <= r_z[NST-1] ? '0 : r_d[NST-1];
        end
    end
endmodule

// File: tb/tb_spm_line_responder.sv
// Randomized bench for spm_line_responder against a queue-based model.
// Ports: none (top-level testbench).
module tb_spm_line_responder;
    localparam int ADDR_W = 40;
    localparam int LINE_W = 512;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;
    localparam int QD     = 8;
    localparam int IW     = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              resp_hold = 1'b0;
    logic              ld_val = 1'b0;
    logic [IW-1:0]     ld_idx = '0;
    logic [LINE_W-1:0] ld_data = '0;
    logic              addr_err;

    spm_line_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    spm_line_responder #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH_LINES(DEPTH),
        .LATENCY(LAT), .QDEPTH(QD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .resp_hold(resp_hold), .ld_val(ld_val), .ld_idx(ld_idx),
        .ld_data(ld_data), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(string tag, logic [LINE_W-1:0] got,
                         logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: each accepted request becomes a queue entry that is due
    // LAT cycles after acceptance and leaves when at head, due, unheld.
    typedef struct {
        logic [5:0]        tid;
        logic [LINE_W-1:0] data;
        int                due;
    } ent_t;

    ent_t              q[$];
    logic [LINE_W-1:0] mmem [16];
    logic              m_err = 1'b0;
    int                cyc = 0;
    int                n_dut_hsk = 0;

    always @(negedge clk) begin
        logic exp_rdy, exp_val, oor;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            exp_rdy = (q.size() < QD) && !ld_val;
            check("rdy", LINE_W'(bus.mem_req_rdy), LINE_W'(exp_rdy));
            exp_val = !resp_hold && q.size() > 0 && q[0].due <= cyc;
            check("resp_val", LINE_W'(bus.mem_resp_val), LINE_W'(exp_val));
            if (exp_val) begin
                check("resp_tid", LINE_W'(bus.mem_resp_transid),
                      LINE_W'(q[0].tid));
                check("resp_data", bus.mem_resp_data, q[0].data);
                void'(q.pop_front());
            end else begin
                check("idle_tid", LINE_W'(bus.mem_resp_transid), '0);
                check("idle_data", bus.mem_resp_data, '0);
            end
            check("addr_err", LINE_W'(addr_err), LINE_W'(m_err));
            if (bus.mem_req_val && bus.mem_req_rdy) n_dut_hsk++;
            if (bus.mem_req_val && exp_rdy) begin
                oor = (bus.mem_req_addr >> 16) != 0;
                e.tid  = bus.mem_req_transid;
                e.data = oor ? '0 : mmem[bus.mem_req_addr[9:6]];
                e.due  = cyc + LAT;
                q.push_back(e);
                if (oor) m_err = 1'b1;
            end
            if (ld_val) mmem[ld_idx[3:0]] = ld_data;
        end
        cyc++;
    end

    function automatic logic [LINE_W-1:0] seq_line(int base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'(base + k);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int idx, logic [LINE_W-1:0] d);
        ld_val  = 1'b1;
        ld_idx  = IW'(idx);
        ld_data = d;
        step();
        ld_val  = 1'b0;
    endtask

    task automatic req(logic [5:0] t, logic [ADDR_W-1:0] a);
        bus.mem_req_val     = 1'b1;
        bus.mem_req_transid = t;
        bus.mem_req_addr    = a;
        step();
    endtask

    task automatic idle(int n);
        bus.mem_req_val = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        bus.mem_req_val     = 1'b0;
        bus.mem_req_transid = '0;
        bus.mem_req_addr    = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i >= 1 && i <= 3) load(i, seq_line(i * 256));
            else load(i, rnd_line());
        end
        idle(2);

        req(6'd5, 40'h40);
        idle(8);

        req(6'd0, 40'h40);
        req(6'd1, 40'h80);
        req(6'd2, 40'hC0);
        idle(8);

        resp_hold = 1'b1;
        n_dut_hsk = 0;
        for (int i = 0; i < 12; i++) req(6'(i), 40'(i % 16) << 6);
        bus.mem_req_val = 1'b0;
        check("hold_hsk", LINE_W'(n_dut_hsk), LINE_W'(8));
        check("hold_rdy", LINE_W'(bus.mem_req_rdy), '0);
        resp_hold = 1'b0;
        idle(12);

        req(6'd7, 40'h47);
        idle(6);
        check("err_unaligned", LINE_W'(addr_err), '0);
        req(6'd9, 40'h100_0000);
        idle(6);
        check("err_set", LINE_W'(addr_err), LINE_W'(1));
        idle(3);
        check("err_sticky", LINE_W'(addr_err), LINE_W'(1));

        ld_val  = 1'b1;
        ld_idx  = IW'(1);
        ld_data = seq_line(32'h5500);
        req(6'd11, 40'h40);
        ld_val = 1'b0;
        req(6'd12, 40'h40);
        idle(8);

        req(6'd20, 40'h40);
        req(6'd21, 40'h80);
        req(6'd22, 40'hC0);
        bus.mem_req_val = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_err", LINE_W'(addr_err), '0);
        check("rst_rdy", LINE_W'(bus.mem_req_rdy), LINE_W'(1));
        idle(10);

        for (int i = 0; i < 600; i++) begin
            resp_hold = ($urandom % 4) == 0;
            ld_val    = ($urandom % 10) == 0;
            ld_idx    = IW'($urandom % 16);
            ld_data   = rnd_line();
            bus.mem_req_val     = ($urandom % 3) != 0;
            bus.mem_req_transid = 6'($urandom);
            a = (40'($urandom % 16) << 6) | 40'($urandom % 64);
            if (($urandom % 10) == 0) a = a | (40'h1 << $urandom_range(16, 39));
            bus.mem_req_addr = a;
            step();
        end
        ld_val    = 1'b0;
        resp_hold = 1'b0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
